adc_sequencer: RTL and testbench

ADC_SEQUENCER -- requirements
Module: adc_sequencer

---
 rtl/adc_seq_pkg.sv | 15 +
 rtl/sync_2ff.sv | 31 +++
 rtl/adc_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_adc_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared types and defaults for the ADC burst sequencer.
package adc_seq_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int IDX_W_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_WAIT_READY = 3'd2,
        ST_WAIT_PERIOD = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous start switch into fpga_clk.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: plain shift through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/adc_sequencer.sv
// ADC burst sequencer: issues periodic conversion requests to an ADC serial
// driver, captures returned samples and reports overrun/timeout conditions.
// Optional macro ADC_SEQ_TIMEOUT_EN enables the adc_ready timeout watchdog;
// without it WAIT_READY waits indefinitely and timeout_err stays 0.
//
// Handshake: adc_start is a one-cycle request, only issued while adc_busy is
// low; adc_ready is a one-cycle pulse qualifying adc_data and is only honoured
// in WAIT_READY. sample_valid is a one-cycle strobe for sample_out and
// sample_index; there is no backpressure.
module adc_sequencer
    import adc_seq_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int SAMPLE_PERIOD  = 100,
    parameter int BURST_LEN      = 16,
    parameter int IDX_W          = IDX_W_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              fpga_clk,
    input  logic              button_rst,
    input  logic              start_switch,
    output logic              adc_start,
    input  logic              adc_busy,
    input  logic              adc_ready,
    input  logic [DATA_W-1:0] adc_data,
    output logic              sample_valid,
    output logic [DATA_W-1:0] sample_out,
    output logic [IDX_W-1:0]  sample_index,
    output logic              burst_done,
    output logic              overrun,
    output logic              timeout_err,
    output logic [2:0]        dbg_state
);

    localparam int PCNT_W = $clog2(SAMPLE_PERIOD + 1);
    localparam int BCNT_W = (BURST_LEN > 0) ? $clog2(BURST_LEN + 1) : 1;

    state_t              state_q, state_d;
    logic                sw_sync;
    logic                sw_prev_q, sw_prev_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                adc_start_q, adc_start_d;
    logic                sample_valid_q, sample_valid_d;
    logic [DATA_W-1:0]   sample_out_q, sample_out_d;
    logic [IDX_W-1:0]    sample_index_q, sample_index_d;
    logic                burst_done_q, burst_done_d;
    logic                overrun_q, overrun_d;
    logic                timeout_q, timeout_d;
    logic                want_issue;
    logic                sw_rise;
    logic                period_done;
    logic                last_sample;
`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
`endif

    sync_2ff u_sync (
        .clk (fpga_clk),
        .rst (button_rst),
        .d   (start_switch),
        .q   (sw_sync)
    );

    assign sw_rise     = sw_sync & ~sw_prev_q;
    assign period_done = (pcnt_q == '0);
    assign last_sample = (BURST_LEN != 0) && (bcnt_q == BCNT_W'(BURST_LEN - 1));

    // Next-state and output logic; the period counter free-runs down to zero
    // after each adc_start and a conversion is requested via want_issue.
    always_comb begin
        state_d        = state_q;
        sw_prev_d      = sw_sync;
        pcnt_d         = period_done ? pcnt_q : pcnt_q - 1'b1;
        bcnt_d         = bcnt_q;
        idx_d          = idx_q;
        adc_start_d    = 1'b0;
        sample_valid_d = 1'b0;
        sample_out_d   = sample_out_q;
        sample_index_d = sample_index_q;
        burst_done_d   = (state_q == ST_DONE) && sample_valid_q;
        overrun_d      = overrun_q;
        timeout_d      = timeout_q;
        want_issue     = 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
        tcnt_d         = tcnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (sw_rise) begin
                    overrun_d  = 1'b0;
                    timeout_d  = 1'b0;
                    bcnt_d     = '0;
                    idx_d      = '0;
                    want_issue = 1'b1;
                end
            end
            ST_START: begin
                if (!sw_sync) begin
                    state_d = ST_IDLE;
                end else begin
                    want_issue = 1'b1;
                end
            end
            ST_WAIT_READY: begin
                if (adc_ready) begin
                    sample_valid_d = 1'b1;
                    sample_out_d   = adc_data;
                    sample_index_d = idx_q;
                    idx_d          = idx_q + 1'b1;
                    bcnt_d         = bcnt_q + 1'b1;
                    if (last_sample) begin
                        state_d = ST_DONE;
                    end else if (!sw_sync) begin
                        state_d = ST_IDLE;
                    end else if (period_done) begin
                        want_issue = 1'b1;
                    end else begin
                        state_d = ST_WAIT_PERIOD;
                    end
                end else begin
                    if (period_done) begin
                        overrun_d = 1'b1;
                    end
`ifdef ADC_SEQ_TIMEOUT_EN
                    if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
`endif
                end
            end
            ST_WAIT_PERIOD: begin
                if (!sw_sync) begin
                    state_d = ST_IDLE;
                end else if (period_done) begin
                    want_issue = 1'b1;
                end
            end
            ST_DONE: begin
                if (!sw_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (want_issue) begin
            if (!adc_busy) begin
                adc_start_d = 1'b1;
                pcnt_d      = PCNT_W'(SAMPLE_PERIOD - 1);
                state_d     = ST_WAIT_READY;
`ifdef ADC_SEQ_TIMEOUT_EN
                tcnt_d      = '0;
`endif
            end else begin
                state_d = ST_START;
            end
        end
    end

    // State, counters and registered outputs; reset discards any pending sample.
    always_ff @(posedge fpga_clk or posedge button_rst) begin
        if (button_rst) begin
            state_q        <= ST_IDLE;
            sw_prev_q      <= 1'b0;
            pcnt_q         <= '0;
            bcnt_q         <= '0;
            idx_q          <= '0;
            adc_start_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_out_q   <= '0;
            sample_index_q <= '0;
            burst_done_q   <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
            tcnt_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            sw_prev_q      <= sw_prev_d;
            pcnt_q         <= pcnt_d;
            bcnt_q         <= bcnt_d;
            idx_q          <= idx_d;
            adc_start_q    <= adc_start_d;
            sample_valid_q <= sample_valid_d;
            sample_out_q   <= sample_out_d;
            sample_index_q <= sample_index_d;
            burst_done_q   <= burst_done_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
`ifdef ADC_SEQ_TIMEOUT_EN
            tcnt_q         <= tcnt_d;
`endif
        end
    end

    assign adc_start    = adc_start_q;
    assign sample_valid = sample_valid_q;
    assign sample_out   = sample_out_q;
    assign sample_index = sample_index_q;
    assign burst_done   = burst_done_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Self-checking bench for adc_sequencer: a burst instance (BURST_LEN=4) driven
// by a randomized ADC responder model, and a continuous instance (IDX_W=2).
module tb_adc_sequencer;
    import adc_seq_pkg::*;

    localparam int DW = 12;
    localparam int P  = 20;
    localparam int BL = 4;
    localparam int TO = 50;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst;

    // ---------------- DUT A (burst) ----------------
    logic          start_a;
    logic          resp_busy;
    logic          hold_busy;
    logic          adc_busy_a;
    logic          adc_ready_a;
    logic [DW-1:0] adc_data_a;
    logic          adc_start_a;
    logic          sample_valid_a;
    logic [DW-1:0] sample_out_a;
    logic [7:0]    sample_index_a;
    logic          burst_done_a;
    logic          overrun_a;
    logic          timeout_err_a;
    logic [2:0]    dbg_state_a;

    assign adc_busy_a = resp_busy | hold_busy;

    adc_sequencer #(
        .DATA_W(DW), .SAMPLE_PERIOD(P), .BURST_LEN(BL), .IDX_W(8), .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .fpga_clk(clk), .button_rst(rst), .start_switch(start_a),
        .adc_start(adc_start_a), .adc_busy(adc_busy_a), .adc_ready(adc_ready_a),
        .adc_data(adc_data_a), .sample_valid(sample_valid_a), .sample_out(sample_out_a),
        .sample_index(sample_index_a), .burst_done(burst_done_a), .overrun(overrun_a),
        .timeout_err(timeout_err_a), .dbg_state(dbg_state_a)
    );

    // ---------------- DUT B (continuous, 2-bit index) ----------------
    logic          start_b;
    logic [7:0]    dly_b;
    logic [31:0]   rnd_b;
    logic          adc_ready_b;
    logic          adc_busy_b;
    logic [DW-1:0] adc_data_b;
    logic          adc_start_b;
    logic          sample_valid_b;
    logic [DW-1:0] sample_out_b;
    logic [1:0]    sample_index_b;
    logic          burst_done_b;
    logic          overrun_b;
    logic          timeout_err_b;
    logic [2:0]    dbg_state_b;

    // Fixed-latency ADC for B: ready 8 cycles after each start, random data.
    always @(posedge clk) begin
        dly_b <= {dly_b[6:0], adc_start_b};
        rnd_b <= $urandom;
    end
    assign adc_ready_b = dly_b[7];
    assign adc_busy_b  = |dly_b[6:0];
    assign adc_data_b  = rnd_b[DW-1:0];

    adc_sequencer #(
        .DATA_W(DW), .SAMPLE_PERIOD(P), .BURST_LEN(0), .IDX_W(2), .TIMEOUT_CYCLES(TO)
    ) u_dut_c (
        .fpga_clk(clk), .button_rst(rst), .start_switch(start_b),
        .adc_start(adc_start_b), .adc_busy(adc_busy_b), .adc_ready(adc_ready_b),
        .adc_data(adc_data_b), .sample_valid(sample_valid_b), .sample_out(sample_out_b),
        .sample_index(sample_index_b), .burst_done(burst_done_b), .overrun(overrun_b),
        .timeout_err(timeout_err_b), .dbg_state(dbg_state_b)
    );

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- stimulus control (owned by main) ----------------
    logic resp_en;
    int   fixed_lat;
    int   first_start_cyc;
    int   burst_id;
    int   epoch;

    // ---------------- ADC responder + start-time model for A ----------------
    // Model: first start of a burst lands 3 edges after the switch rises; each
    // following start is max(prev_start + P, ready + 1). Overrun iff latency >= P.
    logic [19:0] exp_q[$];
    int   starts_a   = 0;
    int   model_idx  = 0;
    int   seen_burst = 0;
    int   exp_start  = 0;
    bit   ov_exp     = 1'b0;
    int   t0, lat, ep;
    logic [DW-1:0] rdat;

    initial begin
        resp_busy   = 1'b0;
        adc_ready_a = 1'b0;
        adc_data_a  = '0;
        forever begin
            @(posedge clk);
            #1;
            adc_ready_a = 1'b0;
            if (adc_start_a) begin
                if (burst_id != seen_burst) begin
                    seen_burst = burst_id;
                    model_idx  = 0;
                    ov_exp     = 1'b0;
                    exp_start  = first_start_cyc;
                end
                check("start_time", cyc, exp_start);
                starts_a++;
                if (resp_en) begin
                    t0  = cyc;
                    ep  = epoch;
                    lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(30, 3);
                    if (lat >= P) ov_exp = 1'b1;
                    exp_start = (P > lat + 1) ? t0 + P : t0 + lat + 1;
                    resp_busy = 1'b1;
                    repeat (lat) @(posedge clk);
                    #1;
                    rdat        = DW'($urandom);
                    adc_ready_a = 1'b1;
                    adc_data_a  = rdat;
                    resp_busy   = 1'b0;
                    if (ep == epoch) begin
                        exp_q.push_back({8'(model_idx), rdat});
                        model_idx++;
                    end
                end
            end
        end
    end

    // ---------------- output monitors / scoreboards ----------------
    int   strobes_a = 0;
    int   done_a    = 0;
    int   last_valid_cyc = 0;
    int   to_cyc    = -1;
    logic to_prev   = 1'b0;
    logic [19:0] e_a;

    always @(negedge clk) begin
        if (!rst) begin
            if (burst_done_a) begin
                check("burst_done_time", cyc, last_valid_cyc + 1);
                done_a++;
            end
            if (sample_valid_a) begin
                check("strobe_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e_a = exp_q.pop_front();
                    check("sample_a", {sample_index_a, sample_out_a}, e_a);
                end
                strobes_a++;
                last_valid_cyc = cyc;
            end
            if (timeout_err_a && !to_prev) to_cyc = cyc;
            to_prev = timeout_err_a;
        end
    end

    logic [DW-1:0] exp_b_q[$];
    int strobes_b = 0;
    int done_b    = 0;
    logic [DW-1:0] e_b;

    always @(negedge clk) begin
        if (!rst) begin
            if (sample_valid_b) begin
                check("b_idx", sample_index_b, strobes_b % 4);
                if (exp_b_q.size() != 0) e_b = exp_b_q.pop_front();
                else e_b = '1;
                check("b_data", sample_out_b, e_b);
                strobes_b++;
            end
            if (burst_done_b) done_b++;
            if (adc_ready_b && dbg_state_b == ST_WAIT_READY) exp_b_q.push_back(adc_data_b);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_burst();
        burst_id++;
        first_start_cyc = cyc + 3;
        start_a = 1'b1;
    endtask

    task automatic wait_done(input int base, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (done_a != base) break;
            step(1);
        end
    endtask

    task automatic wait_starts(input int target, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (starts_a >= target) break;
            step(1);
        end
    endtask

    task automatic end_burst();
        start_a = 1'b0;
        step(6);
        check("back_to_idle", dbg_state_a, ST_IDLE);
    endtask

    // ---------------- main sequence ----------------
    int bs, bd, bn;

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; hold_busy = 1'b0;
        resp_en = 1'b1; fixed_lat = 10; first_start_cyc = -1; burst_id = 0; epoch = 0;
        step(3);
        check("rst_outputs_a", {adc_start_a, sample_valid_a, burst_done_a, overrun_a,
                                timeout_err_a, sample_out_a, sample_index_a}, 0);
        check("rst_state_a", dbg_state_a, ST_IDLE);
        check("rst_outputs_b", {adc_start_b, sample_valid_b, sample_index_b}, 0);
        rst = 1'b0;
        step(2);

        // Basic burst: fixed latency 10.
        bs = strobes_a; bd = done_a; bn = starts_a;
        fixed_lat = 10;
        start_burst();
        wait_done(bd, 200);
        step(3);
        check("t1_strobes", strobes_a - bs, 4);
        check("t1_done", done_a - bd, 1);
        check("t1_starts", starts_a - bn, 4);
        check("t1_overrun", overrun_a, 0);
        check("t1_state_done", dbg_state_a, ST_DONE);
        end_burst();

        // Continuous instance: index wraps 0..3, never burst_done.
        start_b = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (strobes_b >= 6) break;
            step(1);
        end
        start_b = 1'b0;
        step(30);
        check("b_strobes_min", strobes_b >= 6, 1);
        check("b_no_done", done_b, 0);
        check("b_idle", dbg_state_b, ST_IDLE);

        // Randomized latencies: overrun predicted from the drawn latencies.
        fixed_lat = 0;
        for (int k = 0; k < 4; k++) begin
            bs = strobes_a; bd = done_a; bn = starts_a;
            start_burst();
            wait_done(bd, 400);
            step(3);
            check("rnd_strobes", strobes_a - bs, 4);
            check("rnd_done", done_a - bd, 1);
            check("rnd_starts", starts_a - bn, 4);
            check("rnd_overrun", overrun_a, ov_exp);
            end_burst();
        end

        // Late ready: overrun sets, restart one cycle after ready.
        fixed_lat = 25;
        bs = strobes_a; bd = done_a;
        start_burst();
        wait_done(bd, 400);
        step(3);
        check("t3_overrun", overrun_a, 1);
        check("t3_strobes", strobes_a - bs, 4);
        end_burst();
        check("t3_overrun_sticky", overrun_a, 1);

        // Switch drops during 2nd conversion: that sample still emitted.
        fixed_lat = 10;
        bs = strobes_a; bd = done_a; bn = starts_a;
        start_burst();
        wait_starts(bn + 2, 100);
        start_a = 1'b0;
        step(40);
        check("t4_strobes", strobes_a - bs, 2);
        check("t4_starts", starts_a - bn, 2);
        check("t4_no_done", done_a - bd, 0);
        check("t4_last_idx", sample_index_a, 1);
        check("t4_overrun_cleared", overrun_a, 0);
        check("t4_idle", dbg_state_a, ST_IDLE);

        // adc_busy high at start: request held in START until busy drops.
        bn = starts_a;
        hold_busy = 1'b1;
        burst_id++;
        first_start_cyc = -1;
        start_a = 1'b1;
        step(8);
        check("t5_no_start", starts_a - bn, 0);
        check("t5_state_start", dbg_state_a, ST_START);
        first_start_cyc = cyc + 1;
        hold_busy = 1'b0;
        step(3);
        check("t5_start", starts_a - bn, 1);
        start_a = 1'b0;
        step(40);
        check("t5_idle", dbg_state_a, ST_IDLE);

        // Reset during WAIT_READY: pending sample dropped, stray ready ignored.
        fixed_lat = 15;
        bs = strobes_a; bn = starts_a;
        start_burst();
        wait_starts(bn + 1, 50);
        step(5);
        check("t6_wait_ready", dbg_state_a, ST_WAIT_READY);
        #2;
        rst = 1'b1;
        start_a = 1'b0;
        epoch++;
        #1;
        check("t6_rst_outputs", {adc_start_a, sample_valid_a, burst_done_a, overrun_a,
                                 timeout_err_a, sample_out_a, sample_index_a}, 0);
        check("t6_rst_state", dbg_state_a, ST_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(30);
        check("t6_no_strobe", strobes_a - bs, 0);
        check("t6_idle", dbg_state_a, ST_IDLE);

        // ADC never answers.
        resp_en = 1'b0;
        bn = starts_a;
        start_burst();
        wait_starts(bn + 1, 50);
        step(60);
`ifdef ADC_SEQ_TIMEOUT_EN
        check("t7_timeout", timeout_err_a, 1);
        check("t7_timeout_cycle", to_cyc, first_start_cyc + TO);
        check("t7_idle", dbg_state_a, ST_IDLE);
`else
        check("t7_no_timeout", timeout_err_a, 0);
        check("t7_stuck_wait", dbg_state_a, ST_WAIT_READY);
`endif
        start_a = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        check("t7_reset_clears", {timeout_err_a, overrun_a}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the sequence above is a few thousand cycles.
    initial begin
        #500000;
        $display("FAIL watchdog: got=%0d expected=%0d cycles", cyc, 50000);
        $fatal(1, "watchdog expired");
    end

endmodule
